// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: packs UART bytes big-endian into imem words, then
// runs or single-steps the fetch stage until the HALT instruction is fetched.
module fetch_sequencer #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       fetched_instr,
  output logic              start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              pc_enable,
  output logic              cpu_reset,
  output logic              halted,
  output logic              overflow,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RUN_INIT, S_RUN, S_STEP_INIT, S_STEP, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [23:0]       shift, shift_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [ADDR_W-1:0] wr_addr_n, words_n;
  logic [31:0]       wr_data_n;
  logic              start_n, pc_enable_n, cpu_reset_n, halted_n, overflow_n;
  logic              cmd_load, step_pulse;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      shift        <= '0;
      byte_cnt     <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
      start        <= 1'b1;
      pc_enable    <= 1'b0;
      cpu_reset    <= 1'b0;
      halted       <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      shift        <= shift_n;
      byte_cnt     <= byte_cnt_n;
      wr_addr      <= wr_addr_n;
      wr_data      <= wr_data_n;
      words_loaded <= words_n;
      start        <= start_n;
      pc_enable    <= pc_enable_n;
      cpu_reset    <= cpu_reset_n;
      halted       <= halted_n;
      overflow     <= overflow_n;
    end
  end

  // Next state; outputs are derived from the state being entered
  always_comb begin
    state_n     = state;
    shift_n     = shift;
    byte_cnt_n  = byte_cnt;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    words_n     = words_loaded;
    halted_n    = halted;
    overflow_n  = overflow;
    start_n     = 1'b1;
    pc_enable_n = 1'b0;
    cpu_reset_n = 1'b0;
    cmd_load    = 1'b0;
    step_pulse  = 1'b0;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD: cmd_load = 1'b1;
            CMD_RUN:  state_n = S_RUN_INIT;
            CMD_STEP: state_n = S_STEP_INIT;
            default:  ;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) begin
            byte_cnt_n = '0;
            if (words_loaded == ADDR_W'(MEM_WORDS)) begin
              overflow_n = 1'b1;
              state_n    = S_IDLE;
            end else begin
              wr_data_n = {shift, rx_data};
              start_n   = 1'b0;
              state_n   = S_WRITE;
            end
          end else begin
            shift_n    = {shift[15:0], rx_data};
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end
      S_WRITE: begin
        wr_addr_n  = wr_addr + ADDR_W'(4);
        words_n    = words_loaded + ADDR_W'(1);
        byte_cnt_n = '0;
        if (wr_data == HALT_WORD) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_LOAD;
          // A byte arriving during the write cycle starts the next word
          if (rx_valid) begin
            shift_n    = {shift[15:0], rx_data};
            byte_cnt_n = 2'd1;
          end
        end
      end
      S_RUN_INIT:  state_n = S_RUN;
      S_STEP_INIT: state_n = S_STEP;
      S_RUN: begin
        if (fetched_instr == HALT_WORD) begin
          halted_n = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_STEP: begin
        if (fetched_instr == HALT_WORD) begin
          halted_n = 1'b1;
          state_n  = S_DONE;
        end else if (rx_valid) begin
          case (rx_data)
            CMD_NEXT: step_pulse = 1'b1;
            CMD_RUN:  state_n = S_RUN;
            CMD_STEP: state_n = S_STEP_INIT;
            CMD_LOAD: cmd_load = 1'b1;
            default:  ;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (cmd_load) begin
      state_n    = S_LOAD;
      wr_addr_n  = '0;
      words_n    = '0;
      byte_cnt_n = '0;
      overflow_n = 1'b0;
      halted_n   = 1'b0;
    end

    // PC reset always travels with pc_enable
    if (state_n == S_RUN_INIT || state_n == S_STEP_INIT) begin
      pc_enable_n = 1'b1;
      cpu_reset_n = 1'b1;
      halted_n    = 1'b0;
    end else if (state_n == S_RUN || step_pulse) begin
      pc_enable_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the imem and fetch stage, drives UART bytes,
// and checks writes and PC-enable activity against a behavioural model.
module tb_fetch_sequencer;

  localparam int unsigned MW = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] fetched_instr;
  logic        start, pc_enable, cpu_reset, halted, overflow;
  logic [31:0] wr_addr, wr_data, words_loaded;

  fetch_sequencer #(.HALT_WORD(HALT), .MEM_WORDS(MW), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetched_instr(fetched_instr), .start(start), .wr_addr(wr_addr),
    .wr_data(wr_data), .pc_enable(pc_enable), .cpu_reset(cpu_reset),
    .halted(halted), .overflow(overflow), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Fetch stage and instruction memory as seen by the sequencer
  logic [31:0] imem [0:63];
  logic [31:0] pc = 32'h0;
  assign fetched_instr = imem[pc[7:2]];
  initial for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  always @(posedge clk) begin
    if (!start) imem[wr_addr[7:2]] <= wr_data;
    if (pc_enable) pc <= cpu_reset ? 32'h0 : pc + 32'd4;
  end

  int errors = 0, checks = 0;
  int pe_cnt = 0, rst_cnt = 0, viol = 0;
  logic [63:0] wq[$], exp_w[$];
  logic [7:0]  bytes[$];
  bit          exp_ovf;

  always @(negedge clk) if (!reset) begin
    if (!start) wq.push_back({wr_addr, wr_data});
    if (pc_enable) pe_cnt++;
    if (cpu_reset) rst_cnt++;
    if ((cpu_reset && !pc_enable) || (!start && pc_enable)) viol++;
  end

  task automatic idle(input int n); repeat (n) @(negedge clk); endtask

  task automatic clr();
    @(posedge clk); #1;
    wq.delete(); pe_cnt = 0; rst_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_stream(input bit b2b);
    foreach (bytes[i]) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = bytes[i];
      if (!b2b) begin @(negedge clk); rx_valid = 1'b0; end
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int s = 3; s >= 0; s--) bytes.push_back(w[s*8 +: 8]);
  endtask

  function automatic logic [31:0] rword();
    logic [31:0] w = $urandom;
    return (w == HALT) ? 32'h0 : w;
  endfunction

  // Reference: each 4-byte group is a word written at 4*index, until HALT or capacity
  task automatic model_load();
    int cnt = 0;
    exp_w.delete(); exp_ovf = 1'b0;
    for (int i = 0; i + 3 < bytes.size(); i += 4) begin
      logic [31:0] w = {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
      if (cnt == int'(MW)) begin exp_ovf = 1'b1; break; end
      exp_w.push_back({32'(cnt * 4), w});
      cnt++;
      if (w == HALT) break;
    end
  endtask

  task automatic wait_halted(output bit ok);
    int t = 0;
    while (halted !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    ok = (halted === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(3); reset = 1'b0;
    checks++; if ({start, pc_enable, cpu_reset, halted, overflow} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got=%b want=10000", {start, pc_enable, cpu_reset, halted, overflow}); end
    checks++; if ({wr_addr, wr_data, words_loaded} !== 96'h0) begin
      errors++; $display("FAIL reset_buses addr=%h data=%h words=%0d want zeros", wr_addr, wr_data, words_loaded); end
  endtask

  task automatic test_load_basic();
    clr(); bytes = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send(8'h4C); send_stream(1'b0); idle(3);
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL basic_count got=%0d want=2", wq.size()); end
    else begin
      checks++; if (wq[0] !== 64'h00000000_00000001) begin errors++; $display("FAIL basic_w0 got=%h want=0000000000000001", wq[0]); end
      checks++; if (wq[1] !== 64'h00000004_FFFFFFFF) begin errors++; $display("FAIL basic_w1 got=%h want=00000004ffffffff", wq[1]); end
    end
    checks++; if (words_loaded !== 32'd2 || start !== 1'b1) begin
      errors++; $display("FAIL basic_words got=%0d start=%b want=2 start=1", words_loaded, start); end
  endtask

  task automatic test_run_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 3);
      bit ok;
      bytes.delete();
      for (int k = 0; k < n; k++) push_word(rword());
      push_word(HALT); model_load();
      clr(); send(8'h4C); send_stream(it[0]); idle(3);
      checks++; if (wq.size() !== exp_w.size()) begin
        errors++; $display("FAIL run_load_count it=%0d got=%0d want=%0d", it, wq.size(), exp_w.size()); end
      else foreach (exp_w[i]) begin
        checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL run_load_word it=%0d i=%0d got=%h want=%h", it, i, wq[i], exp_w[i]); end
      end
      clr(); send(8'h52); wait_halted(ok);
      checks++; if (!ok) begin errors++; $display("FAIL run_timeout it=%0d halted=%b want=1", it, halted); end
      checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL run_halt_pe it=%0d got=%b want=0", it, pc_enable); end
      idle(3);
      checks++; if (pe_cnt !== n + 2 || rst_cnt !== 1) begin
        errors++; $display("FAIL run_counts it=%0d pe=%0d rst=%0d want pe=%0d rst=1", it, pe_cnt, rst_cnt, n + 2); end
    end
  endtask

  task automatic test_step();
    int k = $urandom_range(1, 3);
    bit ok;
    bytes.delete();
    for (int i = 0; i < k; i++) push_word(rword());
    push_word(HALT);
    send(8'h4C); send_stream(1'b1); idle(3);
    clr(); send(8'h53); idle(3);
    for (int p = 0; p < k + 2; p++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h4E;
      @(negedge clk); rx_valid = 1'b0;
      checks++; if (pc_enable !== (p < k)) begin errors++; $display("FAIL step_pulse p=%0d got=%b want=%b", p, pc_enable, p < k); end
      @(negedge clk);
      checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL step_width p=%0d got=%b want=0", p, pc_enable); end
      idle(3);
    end
    checks++; if (halted !== 1'b1 || pe_cnt !== k + 1 || rst_cnt !== 1) begin
      errors++; $display("FAIL step_totals halted=%b pe=%0d rst=%0d want 1 %0d 1", halted, pe_cnt, rst_cnt, k + 1); end
    clr(); send(8'h52); wait_halted(ok); idle(3);
    checks++; if (!ok || pe_cnt !== k + 2 || rst_cnt !== 1) begin
      errors++; $display("FAIL done_rerun ok=%b pe=%0d rst=%0d want 1 %0d 1", ok, pe_cnt, rst_cnt, k + 2); end
  endtask

  task automatic test_step_to_run();
    int k = $urandom_range(2, 3);
    bit ok;
    bytes.delete();
    for (int i = 0; i < k; i++) push_word(rword());
    push_word(HALT);
    send(8'h4C); send_stream(1'b0); idle(3);
    clr(); send(8'h53); idle(2); send(8'h4E); idle(3); send(8'h52);
    wait_halted(ok); idle(3);
    checks++; if (!ok || pe_cnt !== k + 2 || rst_cnt !== 1) begin
      errors++; $display("FAIL step_to_run ok=%b pe=%0d rst=%0d want 1 %0d 1", ok, pe_cnt, rst_cnt, k + 2); end
  endtask

  task automatic test_overflow();
    bytes.delete();
    for (int i = 0; i < 5; i++) push_word(rword());
    model_load();
    clr(); send(8'h4C); send_stream(1'b1); idle(3);
    checks++; if (wq.size() !== 4 || exp_w.size() !== 4) begin
      errors++; $display("FAIL ovf_count got=%0d want=4", wq.size()); end
    else foreach (exp_w[i]) begin
      checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL ovf_word i=%0d got=%h want=%h", i, wq[i], exp_w[i]); end
    end
    checks++; if (overflow !== exp_ovf || words_loaded !== 32'd4) begin
      errors++; $display("FAIL ovf_flag got=%b words=%0d want=1 words=4", overflow, words_loaded); end
    send(8'h41); idle(2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    bytes.delete(); push_word(HALT);
    send(8'h4C); send_stream(1'b0); idle(3);
    checks++; if (overflow !== 1'b0 || words_loaded !== 32'd1) begin
      errors++; $display("FAIL ovf_clear got=%b words=%0d want=0 words=1", overflow, words_loaded); end
  endtask

  task automatic test_reset_mid();
    clr(); send(8'h4C); send(8'hAA); send(8'hBB);
    reset = 1'b1; idle(2); reset = 1'b0;
    checks++; if (wr_addr !== 32'h0 || start !== 1'b1) begin
      errors++; $display("FAIL mid_reset addr=%h start=%b want 0 1", wr_addr, start); end
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78}; push_word(HALT);
    clr(); send(8'h4C); send_stream(1'b0); idle(3);
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL mid_count got=%0d want=2", wq.size()); end
    else begin
      checks++; if (wq[0] !== 64'h00000000_12345678) begin errors++; $display("FAIL mid_word got=%h want=0000000012345678", wq[0]); end
    end
  endtask

  task automatic test_payload_cmd();
    bytes = '{8'h52, 8'h4C, 8'h53, 8'h4E}; push_word(HALT);
    clr(); send(8'h4C); send_stream(1'b1); idle(4);
    checks++; if (wq.size() !== 2 || pe_cnt !== 0) begin
      errors++; $display("FAIL payload_cmd writes=%0d pe=%0d want 2 0", wq.size(), pe_cnt); end
    else begin
      checks++; if (wq[0] !== 64'h00000000_524C534E) begin errors++; $display("FAIL payload_word got=%h want=00000000524c534e", wq[0]); end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL invariants got=%0d want=0", viol); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_run_random();
    test_step();
    test_step_to_run();
    test_overflow();
    test_reset_mid();
    test_payload_cmd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
